// File: rtl/cache_bram_pkg.sv
// ---------------------------------------------------------------------------
// Module : cache_bram_pkg
// Brief  : Default widths and shared typedefs for the cache_bram block.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package cache_bram_pkg;

    localparam int ADDR_W_DEF      = 16;
    localparam int DATA_W_DEF      = 8;
    localparam int INIT_ADDR_W_DEF = 25;

    typedef logic [DATA_W_DEF-1:0]      byte_t;
    typedef logic [ADDR_W_DEF-1:0]      addr_t;
    typedef logic [INIT_ADDR_W_DEF-1:0] init_addr_t;

endpackage

`default_nettype wire

// File: rtl/cache_bram_if.sv
// ---------------------------------------------------------------------------
// Module : cache_bram_if
// Brief  : Load/read bus of cache_bram; overflow exists only with
//          CACHE_BRAM_ADDR_CHECK_EN defined.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface cache_bram_if
    import cache_bram_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int INIT_ADDR_W = INIT_ADDR_W_DEF
);

    logic                   bram_download;
    logic                   bram_wr;
    logic [INIT_ADDR_W-1:0] bram_init_address;
    logic [DATA_W-1:0]      bram_din;
    logic [ADDR_W-1:0]      addr;
    logic                   cs;
    logic [DATA_W-1:0]      dout;
`ifdef CACHE_BRAM_ADDR_CHECK_EN
    logic                   overflow;
`endif

    modport master (
        output bram_download, bram_wr, bram_init_address, bram_din, addr, cs,
`ifdef CACHE_BRAM_ADDR_CHECK_EN
        input  overflow,
`endif
        input  dout
    );

    modport slave (
        input  bram_download, bram_wr, bram_init_address, bram_din, addr, cs,
`ifdef CACHE_BRAM_ADDR_CHECK_EN
        output overflow,
`endif
        output dout
    );

endinterface

`default_nettype wire

// File: rtl/cache_bram_ram.sv
// ---------------------------------------------------------------------------
// Module : cache_bram_ram
// Brief  : Simple dual-port RAM, one write and one registered read port.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cache_bram_ram #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [DATA_W-1:0] wdata,
    input  wire logic              re,
    input  wire logic [ADDR_W-1:0] raddr,
    output      logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Non-blocking read of mem gives read-first behaviour on a collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/cache_bram.sv
// ---------------------------------------------------------------------------
// Module : cache_bram
// Brief  : Byte-wide image RAM loaded over the download bus, 1-cycle read.
//          Optional macro CACHE_BRAM_ADDR_CHECK_EN drops out-of-range loads.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cache_bram
    import cache_bram_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int INIT_ADDR_W = INIT_ADDR_W_DEF
) (
    input wire logic    clk,
    input wire logic    reset,
    cache_bram_if.slave bus
);

    logic              wr_en;
    logic              rd_en;
    logic              in_range;
    logic              dout_zero;
    logic [DATA_W-1:0] ram_q;

`ifdef CACHE_BRAM_ADDR_CHECK_EN
    logic dl_prev;
    logic overflow_q;

    assign in_range = (bus.bram_init_address >> ADDR_W) == '0;

    always_ff @(posedge clk) begin
        dl_prev <= bus.bram_download;
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            if (bus.bram_download && !dl_prev) begin
                overflow_q <= 1'b0;
            end
            if (bus.bram_download && bus.bram_wr && !in_range) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.overflow = overflow_q;
`else
    assign in_range = 1'b1;

    // Upper load-address bits are deliberately ignored: writes wrap.
    if (INIT_ADDR_W > ADDR_W) begin : g_wrap
        wire unused_upper = &{1'b0, bus.bram_init_address[INIT_ADDR_W-1:ADDR_W]};
    end
`endif

    // Writes proceed during reset; only the read path is reset.
    assign wr_en = bus.bram_download && bus.bram_wr && in_range;
    assign rd_en = bus.cs && !reset;

    cache_bram_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (bus.bram_init_address[ADDR_W-1:0]),
        .wdata (bus.bram_din),
        .re    (rd_en),
        .raddr (bus.addr),
        .rdata (ram_q)
    );

    // The RAM output register has no reset, so a flag masks it to zero
    // until the first read after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_zero <= 1'b1;
        end else if (bus.cs) begin
            dout_zero <= 1'b0;
        end
    end

    assign bus.dout = dout_zero ? '0 : ram_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_bram.sv
// ---------------------------------------------------------------------------
// Module : tb_cache_bram
// Brief  : Self-checking bench for cache_bram with a reference memory model.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cache_bram;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 8;
    localparam int INIT_ADDR_W = 25;

    typedef struct {
        string            tag;
        logic [DATA_W-1:0] val;
    } exp_t;

    logic clk;
    logic reset;

    cache_bram_if #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .INIT_ADDR_W (INIT_ADDR_W)
    ) bus ();

    cache_bram #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .INIT_ADDR_W (INIT_ADDR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] model [2**ADDR_W];
    logic [DATA_W-1:0] last_dout;
    exp_t              sb_q[$];
    int                n_checks;
    int                n_fail;
`ifdef CACHE_BRAM_ADDR_CHECK_EN
    logic              ov_exp;
    logic              dl_prev;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, predict, then compare #1 after posedge.
    task automatic step(input string tag, input bit rst, input bit dl, input bit wr,
                        input int ia, input logic [DATA_W-1:0] din,
                        input logic [ADDR_W-1:0] a, input bit cs);
        exp_t e;
        bit   in_rng;
        @(negedge clk);
        reset                 = rst;
        bus.bram_download     = dl;
        bus.bram_wr           = wr;
        bus.bram_init_address = INIT_ADDR_W'(ia);
        bus.bram_din          = din;
        bus.addr              = a;
        bus.cs                = cs;

        e.tag = tag;
        if (rst)     e.val = '0;
        else if (cs) e.val = model[a];
        else         e.val = last_dout;
        last_dout = e.val;
        sb_q.push_back(e);

`ifdef CACHE_BRAM_ADDR_CHECK_EN
        in_rng = (ia < (1 << ADDR_W));
        if (rst) ov_exp = 1'b0;
        else begin
            if (dl && !dl_prev) ov_exp = 1'b0;
            if (dl && wr && !in_rng) ov_exp = 1'b1;
        end
        dl_prev = dl;
`else
        in_rng = 1'b1;
`endif
        if (dl && wr && in_rng) model[ia[ADDR_W-1:0]] = din;

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, 32'(bus.dout), 32'(e.val));
        end
`ifdef CACHE_BRAM_ADDR_CHECK_EN
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(ov_exp));
`endif
    endtask

    task automatic load(input int ia, input logic [DATA_W-1:0] din);
        step("load", 1'b0, 1'b1, 1'b1, ia, din, '0, 1'b0);
    endtask

    task automatic rd(input string tag, input logic [ADDR_W-1:0] a);
        step(tag, 1'b0, 1'b0, 1'b0, 0, '0, a, 1'b1);
    endtask

    initial begin
        logic [7:0] img [5];
        n_checks  = 0;
        n_fail    = 0;
        last_dout = '0;
`ifdef CACHE_BRAM_ADDR_CHECK_EN
        ov_exp  = 1'b0;
        dl_prev = 1'b0;
`endif
        reset = 1'b1;
        bus.bram_download = 1'b0; bus.bram_wr = 1'b0; bus.bram_init_address = '0;
        bus.bram_din = '0; bus.addr = '0; bus.cs = 1'b0;

        step("reset0", 1'b1, 1'b0, 1'b0, 0, '0, '0, 1'b1);
        step("reset1", 1'b1, 1'b0, 1'b0, 0, '0, '0, 1'b0);

        img = '{8'h16, 8'h16, 8'h24, 8'h00, 8'hC7};
        for (int i = 0; i < 5; i++) load(i, img[i]);
        step("hold_after_reset", 1'b0, 1'b0, 1'b0, 0, '0, 16'd2, 1'b0);
        rd("read_addr2", 16'd2);

        load(6, 8'h80); load(7, 8'h00); load(8, 8'hAB);
        rd("stream6", 16'd6); rd("stream7", 16'd7); rd("stream8", 16'd8);
        step("hold_cs0", 1'b0, 1'b0, 1'b0, 0, '0, 16'd2, 1'b0);

        load(16'h0010, 8'h55);
        step("wr_no_dl", 1'b0, 1'b0, 1'b1, 16'h0010, 8'hFF, 16'd0, 1'b0);
        rd("read_0x10", 16'h0010);

        rd("mid6", 16'd6);
        step("mid_reset", 1'b1, 1'b0, 1'b0, 0, '0, 16'd7, 1'b1);
        step("post_reset_hold", 1'b0, 1'b0, 1'b0, 0, '0, 16'd7, 1'b0);
        rd("post_reset6", 16'd6);

        load(16'h0020, 8'h22);
        step("rw_same", 1'b0, 1'b1, 1'b1, 16'h0020, 8'h11, 16'h0020, 1'b1);
        rd("rw_next", 16'h0020);

        step("wr_in_reset", 1'b1, 1'b1, 1'b1, 16'h0030, 8'h77, 16'd0, 1'b0);
        rd("read_0x30", 16'h0030);

        load(5, 8'h3C);
        step("oob_write", 1'b0, 1'b1, 1'b1, 32'h10005, 8'h99, 16'd0, 1'b0);
        rd("read_0x05", 16'd5);
        step("dl_rise", 1'b0, 1'b1, 1'b0, 0, '0, 16'd4, 1'b1);

        for (int i = 0; i < 16; i++) load(16'h0100 + i, 8'($urandom));
        for (int i = 0; i < 24; i++) begin
            step("rand", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'h0100 + $urandom_range(0, 15), 8'($urandom),
                 16'(16'h0100 + $urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cache_bram.md
CACHE_BRAM -- requirements
Module: cache_bram

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all ports are listed below, clock and reset first.
REQ-002 ADDR_W, default 16: read-address width; memory depth SHALL be 2^ADDR_W bytes.
REQ-003 DATA_W, default 8: data width of bram_din and dout.
REQ-004 INIT_ADDR_W, default 25: width of bram_init_address.
REQ-005 clk  input  1  sole clock; all logic rising-edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 bram_download  input  1  high while the image is being loaded.
REQ-008 bram_wr  input  1  load-byte strobe; qualified by bram_download.
REQ-009 bram_init_address  input  INIT_ADDR_W  load byte address.
REQ-010 bram_din  input  DATA_W  load byte data.
REQ-011 addr  input  ADDR_W  read address.
REQ-012 dout  output  DATA_W  registered read data.
REQ-013 cs  input  1  read enable.

Function
REQ-014 Write: on a clk edge with bram_download=1 and bram_wr=1, mem[bram_init_address[ADDR_W-1:0]] SHALL take bram_din.
REQ-015 bram_wr with bram_download=0 SHALL be ignored.
REQ-016 Read: on a clk edge with cs=1, dout SHALL take mem[addr]; the latency is exactly 1 cycle.
REQ-017 With cs=0, dout SHALL hold its last value.
REQ-018 A back-to-back address sequence with cs=1 SHALL give one new byte per cycle, with no bubbles.
REQ-019 Read and write to the same address in the same cycle SHALL be read-first: dout gets the old byte, and the new byte is visible from the next read.
REQ-020 Reads are allowed while bram_download=1; there is no arbitration and no stall.
REQ-021 Memory contents SHALL be undefined before the first write; no initialisation file.
REQ-022 The memory SHALL map to a single inferred block RAM: one write port and one read port, both on clk.

Reset
REQ-023 When reset=1 on a clk edge, dout SHALL become 0, and a read in that cycle SHALL be suppressed.
REQ-024 Reset SHALL NOT clear memory contents; a write with reset=1 SHALL still be performed.
REQ-025 A read after reset is deasserted SHALL return data written before the reset.

Configuration
REQ-026 Macro CACHE_BRAM_ADDR_CHECK_EN, when defined: a load write whose bram_init_address >= 2^ADDR_W SHALL be dropped, and sticky output overflow (1 bit) SHALL be set.
REQ-027 overflow SHALL be cleared by reset or by a rising edge of bram_download.
REQ-028 Without the macro: bram_init_address upper bits are ignored, writes wrap modulo 2^ADDR_W, and the overflow port SHALL NOT exist.

Structure
REQ-029 Package cache_bram_pkg SHALL hold the default ADDR_W/DATA_W/INIT_ADDR_W constants and the byte/address typedefs.
REQ-030 Sub-module cache_bram_ram (plain dual-port array with registered read) is natural.
REQ-031 The top level SHALL hold write qualification, reset of dout and the optional overflow logic.

Verification
REQ-032 Load 0x16,0x16,0x24,0x00,0xC7 at init addresses 0..4, then read addr=2 with cs=1 -> dout=0x24 one cycle later.
REQ-033 Read address stream 6,7,8 with cs=1 each cycle after loading 0x80,0x00,0xAB there -> dout=0x80,0x00,0xAB on consecutive cycles.
REQ-034 bram_wr=1 with bram_download=0 to addr 0x0010 (old 0x55, new 0xFF) -> read returns 0x55.
REQ-035 Reset=1 mid-stream -> dout=0x00 next cycle; after release, addr=6 still reads 0x80.
REQ-036 Same-cycle write 0x11 and read at 0x0020 (old 0x22) -> dout=0x22, then 0x11 on the following read.
REQ-037 With macro: write at init addr 0x10005 -> overflow=1 and mem[0x0005] unchanged. Without macro: mem[0x0005] is overwritten.
